// File: rtl/tx_lane_stripe.sv
// Stripes 64-byte TX words across 1..16 PIPE lanes, one registered beat per cycle.
// TX_STRIPE_IDLE_FILL_EN: present zero idle beats on the active lanes while empty.
module tx_lane_stripe #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   GEN,
  input  logic [4:0]   LANESNUMBER,
  input  logic [511:0] inData,
  input  logic [63:0]  inDataK,
  input  logic         inValid,
  output logic         inReady,
  input  logic         outReady,
  output logic [511:0] outData,
  output logic [63:0]  outDataK,
  output logic [15:0]  outValid
);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t       state, nxt_state;
  logic [5:0]   cnt, nxt_cnt;
  logic [511:0] hold, nxt_hold;
  logic [63:0]  hold_k, nxt_hold_k;
  logic [2:0]   lgn, nxt_lgn;
  logic [1:0]   lgb, nxt_lgb;
  logic         rst_done;

  logic [2:0]   in_lgn;
  logic [1:0]   in_lgb;
  logic [2:0]   lgc, nxt_lgc;
  logic [5:0]   last_idx;
  logic         hs, consume, last_beat;

  logic [511:0] st_data;
  logic [63:0]  st_k;
  logic [15:0]  st_valid;

  function automatic logic [1:0] width_lg(input int pw);
    case (pw / 8)
      2:       return 2'd1;
      4:       return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [15:0] lane_mask(input logic [2:0] lg);
    return 16'((32'd1 << (32'd1 << lg)) - 32'd1);
  endfunction

  always_comb begin
    case (GEN)
      3'd1:    in_lgb = width_lg(GEN1_PIPEWIDTH);
      3'd2:    in_lgb = width_lg(GEN2_PIPEWIDTH);
      3'd3:    in_lgb = width_lg(GEN3_PIPEWIDTH);
      3'd4:    in_lgb = width_lg(GEN4_PIPEWIDTH);
      3'd5:    in_lgb = width_lg(GEN5_PIPEWIDTH);
      default: in_lgb = 2'd0;
    endcase
  end

  always_comb begin
    case (LANESNUMBER)
      5'd2:    in_lgn = 3'd1;
      5'd4:    in_lgn = 3'd2;
      5'd8:    in_lgn = 3'd3;
      5'd16:   in_lgn = 3'd4;
      default: in_lgn = 3'd0;
    endcase
  end

  // Beat count is 64/C with C a power of two, so the final index is 63 >> log2(C).
  assign lgc       = lgn + {1'b0, lgb};
  assign nxt_lgc   = nxt_lgn + {1'b0, nxt_lgb};
  assign last_idx  = 6'd63 >> lgc;
  assign consume   = (|outValid) & outReady;
  assign last_beat = (state == SEND) && (cnt == last_idx);
  assign inReady   = rst_done & ((state == EMPTY) | (last_beat & consume));
  assign hs        = inValid & inReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      cnt      <= '0;
      hold     <= '0;
      hold_k   <= '0;
      lgn      <= '0;
      lgb      <= '0;
      rst_done <= 1'b0;
      outData  <= '0;
      outDataK <= '0;
      outValid <= '0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      hold     <= nxt_hold;
      hold_k   <= nxt_hold_k;
      lgn      <= nxt_lgn;
      lgb      <= nxt_lgb;
      rst_done <= 1'b1;
      outData  <= st_data;
      outDataK <= st_k;
      outValid <= st_valid;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_hold   = hold;
    nxt_hold_k = hold_k;
    nxt_lgn    = lgn;
    nxt_lgb    = lgb;
    if (hs) begin
      nxt_state  = SEND;
      nxt_cnt    = '0;
      nxt_hold   = inData;
      nxt_hold_k = inDataK;
      nxt_lgn    = in_lgn;
      nxt_lgb    = in_lgb;
    end else if (state == SEND) begin
      if (consume) begin
        if (last_beat) begin
          nxt_state = EMPTY;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 6'd1;
        end
      end
    end else if (!(|outValid) || outReady) begin
      // Idle lanes follow the live configuration, but never while an idle beat is stalled.
      nxt_lgn = in_lgn;
      nxt_lgb = in_lgb;
    end
  end

  // Outputs are computed from next-cycle state and registered, so a stalled beat repeats itself.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    st_data  = '0;
    st_k     = '0;
    st_valid = '0;
    base     = 32'(nxt_cnt) << nxt_lgc;
    idx      = 0;
    if (nxt_state == SEND) begin
      st_valid = lane_mask(nxt_lgn);
      for (int unsigned i = 0; i < 16; i++) begin
        for (int unsigned s = 0; s < 4; s++) begin
          if ((i < (32'd1 << nxt_lgn)) && (s < (32'd1 << nxt_lgb))) begin
            idx = (base + (s << nxt_lgn) + i) % 64;
            st_data[32*i + 8*s +: 8] = nxt_hold[8*idx +: 8];
            st_k[4*i + s]            = nxt_hold_k[idx];
          end
        end
      end
    end else begin
`ifdef TX_STRIPE_IDLE_FILL_EN
      st_valid = lane_mask(nxt_lgn);
`else
      st_valid = '0;
`endif
    end
  end

endmodule

// File: tb/tb_tx_lane_stripe.sv
// Directed bench for tx_lane_stripe: expected beats are queued at each accepted word
// and compared as the DUT presents them.
module tb_tx_lane_stripe;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   GEN;
  logic [4:0]   LANESNUMBER;
  logic [511:0] inData;
  logic [63:0]  inDataK;
  logic         inValid;
  logic         inReady;
  logic         outReady;
  logic [511:0] outData;
  logic [63:0]  outDataK;
  logic [15:0]  outValid;

  always #5 clk = ~clk;

  tx_lane_stripe #(
    .GEN1_PIPEWIDTH(8),
    .GEN2_PIPEWIDTH(16),
    .GEN3_PIPEWIDTH(32),
    .GEN4_PIPEWIDTH(8),
    .GEN5_PIPEWIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .GEN(GEN),
    .LANESNUMBER(LANESNUMBER),
    .inData(inData),
    .inDataK(inDataK),
    .inValid(inValid),
    .inReady(inReady),
    .outReady(outReady),
    .outData(outData),
    .outDataK(outDataK),
    .outValid(outValid)
  );

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic [15:0]  v;
  } beat_t;

  beat_t        sbq[$];
  int           tests = 0;
  int           fails = 0;
  int           beats_seen = 0;
  logic         toggle_en = 1'b0;
  int           phase = 0;
  logic [3:0]   pattern = 4'b1001;
  logic         prev_stall = 1'b0;
  logic [511:0] prev_d;
  logic [63:0]  prev_k;
  logic [15:0]  prev_v;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent model: chunk byte m -> lane m%N, slot m/N.
  function automatic void push_word(input logic [511:0] w, input logic [63:0] wk,
                                    input int gen, input int ln);
    int b, n, c;
    b = (gen == 2) ? 2 : (gen == 3) ? 4 : 1;
    n = (ln == 1 || ln == 2 || ln == 4 || ln == 8 || ln == 16) ? ln : 1;
    c = n * b;
    for (int k = 0; k < 64 / c; k++) begin
      beat_t e;
      e.d = '0;
      e.k = '0;
      e.v = 16'((1 << n) - 1);
      for (int m = 0; m < c; m++) begin
        e.d[32*(m % n) + 8*(m / n) +: 8] = w[8*(k*c + m) +: 8];
        e.k[4*(m % n) + (m / n)]         = wk[k*c + m];
      end
      sbq.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("stall_data", outData, prev_d);
        check("stall_k", {448'd0, outDataK}, {448'd0, prev_k});
        check("stall_valid", {496'd0, outValid}, {496'd0, prev_v});
      end
      if ((|outValid) && outReady) begin
`ifdef TX_STRIPE_IDLE_FILL_EN
        if (sbq.size() == 0 && outData == '0 && outDataK == '0) begin
        end else
`endif
        if (sbq.size() == 0) begin
          check("extra_beat", {496'd0, outValid}, 512'd0);
        end else begin
          beat_t e;
          e = sbq.pop_front();
          check("beat_data", outData, e.d);
          check("beat_k", {448'd0, outDataK}, {448'd0, e.k});
          check("beat_valid", {496'd0, outValid}, {496'd0, e.v});
          beats_seen++;
        end
      end
      prev_stall = (|outValid) && !outReady;
    end else begin
      prev_stall = 1'b0;
    end
    prev_d = outData;
    prev_k = outDataK;
    prev_v = outValid;
  end

  initial begin
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_en) begin
        outReady = pattern[phase];
        phase    = (phase + 1) % 4;
      end
    end
  end

  task automatic send_word(input logic [511:0] w, input logic [63:0] wk,
                           input int gen, input int ln, output int waited);
    GEN         = 3'(gen);
    LANESNUMBER = 5'(ln);
    inData      = w;
    inDataK     = wk;
    inValid     = 1'b1;
    waited      = 0;
    @(negedge clk);
    while (!inReady && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (!inReady) check("accept_timeout", {511'd0, inReady}, 512'd1);
    push_word(w, wk, gen, ln);
    @(posedge clk);
    #1;
    inValid     = 1'b0;
    GEN         = 3'($urandom);
    LANESNUMBER = 5'($urandom);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check("drain", 512'(sbq.size()), 512'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] ramp_word(input int start);
    logic [511:0] w;
    for (int j = 0; j < 64; j++) w[8*j +: 8] = 8'(start + j);
    return w;
  endfunction

  initial begin
    int           waited;
    int           base;
    logic [511:0] w;
    logic [63:0]  wk;

    reset       = 1'b1;
    GEN         = 3'd1;
    LANESNUMBER = 5'd1;
    inData      = '0;
    inDataK     = '0;
    inValid     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_data", outData, 512'd0);
    check("rst_valid", {496'd0, outValid}, 512'd0);
    check("rst_inready", {511'd0, inReady}, 512'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_inready_hold", {511'd0, inReady}, 512'd0);
    @(posedge clk);
    @(negedge clk);
    check("inready_rise", {511'd0, inReady}, 512'd1);
`ifdef TX_STRIPE_IDLE_FILL_EN
    check("idle_valid", {496'd0, outValid}, 512'h1);
`else
    check("idle_valid", {496'd0, outValid}, 512'd0);
`endif
    @(posedge clk);
    #1;

    // Gen1 x4 ramp: 16 beats, explicit check of beat 0
    base = beats_seen;
    send_word(ramp_word(0), 64'h0123_4567_89AB_CDEF, 1, 4, waited);
    @(negedge clk);
    check("x4_beat0", {384'd0, outData[127:0]}, {384'd0, 128'h00000003_00000002_00000001_00000000});
    check("x4_valid0", {496'd0, outValid}, 512'h000F);
    drain(100);
    check("x4_beats", 512'(beats_seen - base), 512'd16);

    // Gen3 x16 back-to-back single-beat words
    send_word(ramp_word(0), 64'($urandom) << 32 | 64'($urandom), 3, 16, waited);
    @(negedge clk);
    check("x16_lane0", {480'd0, outData[31:0]}, {480'd0, 32'h30201000});
    @(posedge clk);
    #1;
    send_word(ramp_word(8'h40), 64'hFFFF_0000_AAAA_5555, 3, 16, waited);
    send_word(ramp_word(8'h80), 64'h1357_9BDF_2468_ACE0, 3, 16, waited);
    check("b2b_no_wait", 512'(waited), 512'd0);
    drain(20);

    // Gen2 x2 with outReady 1,0,0,1
    base      = beats_seen;
    toggle_en = 1'b1;
    w         = ramp_word(8'h20);
    wk        = {32'($urandom), 32'($urandom)};
    send_word(w, wk, 2, 2, waited);
    drain(200);
    toggle_en = 1'b0;
    outReady  = 1'b1;
    check("x2_beats", 512'(beats_seen - base), 512'd16);

    // Illegal lane count and generation fall back to one byte on one lane
    base = beats_seen;
    send_word(ramp_word(8'h55), {32'($urandom), 32'($urandom)}, 1, 3, waited);
    drain(200);
    check("x3_beats", 512'(beats_seen - base), 512'd64);
    base = beats_seen;
    send_word(ramp_word(8'h11), {32'($urandom), 32'($urandom)}, 7, 8, waited);
    drain(100);
    check("gen7_beats", 512'(beats_seen - base), 512'd8);

    // Reset in the middle of a 16-beat word
    base = beats_seen;
    send_word(ramp_word(8'hA0), 64'hDEAD_BEEF_0BAD_F00D, 1, 4, waited);
    waited = 0;
    while (beats_seen < base + 5 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("reach_beat5", 512'(beats_seen - base), 512'd5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    reset = 1'b0;
    base  = beats_seen;
    @(negedge clk);
    check("midrst_data", outData, 512'd0);
    check("midrst_k", {448'd0, outDataK}, 512'd0);
    check("midrst_valid", {496'd0, outValid}, 512'd0);
    check("midrst_inready", {511'd0, inReady}, 512'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_inready_rise", {511'd0, inReady}, 512'd1);
    repeat (20) @(negedge clk);
    check("midrst_no_residual", 512'(beats_seen - base), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_lane_stripe.md
TX_LANE_STRIPE -- requirements
Module: tx_lane_stripe

Interface
REQ-001 SHALL have parameters: GEN1_PIPEWIDTH 8, GEN2_PIPEWIDTH 16, GEN3_PIPEWIDTH 32, GEN4_PIPEWIDTH 8, GEN5_PIPEWIDTH 8 (per-lane PIPE width in bits for each generation).
REQ-002 Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- GEN  in  3  link generation, 1..5.
- LANESNUMBER  in  5  active lane count, 1/2/4/8/16.
- inData  in  512  64-byte TX word; byte j at [8j+:8].
- inDataK  in  64  K flag per inData byte.
- inValid  in  1  inData/inDataK valid.
- inReady  out  1  block accepts word when inValid&inReady.
- outReady  in  1  PHY side accepts current beat.
- outData  out  512  striped data; lane i at [32i+:32], unused upper bits zero.
- outDataK  out  64  striped K; lane i at [4i+:4].
- outValid  out  16  per-lane valid mask.

Function
REQ-003 SHALL derive per-lane byte count B = PIPEWIDTH/8 from GEN via the parameters; GEN outside 1..5 SHALL use 1 byte.
REQ-004 SHALL treat any LANESNUMBER not in {1,2,4,8,16} as 1 lane.
REQ-005 Chunk size C = N*B bytes; each 64-byte word SHALL be emitted as 64/C consecutive beats, beat k carrying word bytes [kC, kC+C).
REQ-006 Within a beat, chunk byte m SHALL go to lane (m mod N), byte slot (m div N) of that lane; matching K bit routed identically.
REQ-007 Bits of lanes >= N and slots >= B SHALL be zero; outValid SHALL equal the low-N-bit mask whenever a beat is presented, else 0.
REQ-008 Accepted word SHALL be stored in a 64-byte holding register; beat counter SHALL advance only on any(outValid)&outReady.
REQ-009 outData/outDataK/outValid SHALL be registered; first beat appears the cycle after the input handshake.
REQ-010 While a beat is presented and outReady=0, all outputs SHALL hold stable.
REQ-011 inReady SHALL be 1 when the holding register is empty, or when the final beat is being consumed this cycle (back-to-back words, no bubble).
REQ-012 GEN and LANESNUMBER SHALL be latched at each input handshake; changes while a word is in flight SHALL not affect that word.
REQ-013 States: EMPTY (no word; inReady=1) and SEND (beats pending); EMPTY->SEND on handshake; SEND->EMPTY on final beat consumed without new handshake; SEND->SEND on final beat with simultaneous handshake (counter reloads to 0).
REQ-014 With C=64 (x16 Gen3), each word SHALL be a single beat.

Reset
REQ-015 While reset=1 on a clock edge: state EMPTY, beat counter 0, holding register cleared, outData=0, outDataK=0, outValid=0, inReady=0.
REQ-016 inReady SHALL rise the first cycle after reset deasserts; reset mid-word SHALL discard the word with no further beats.

Configuration
REQ-017 Macro TX_STRIPE_IDLE_FILL_EN: when defined, in EMPTY the block SHALL present idle beats (outData=0, outDataK=0, outValid=latched lane mask), consumed by outReady like data beats; when undefined, outValid=0 in EMPTY.
REQ-018 Idle beats SHALL not delay acceptance of a new word; the next beat after the handshake SHALL be data.

Verification
REQ-019 GEN=1, LANESNUMBER=4, word bytes 0x00..0x3F, outReady=1 -> 16 beats; beat0 lanes0..3 carry 0x00,0x01,0x02,0x03 at [7:0], outValid=0x000F.
REQ-020 GEN=3, LANESNUMBER=16, two back-to-back words -> inReady held 1, one beat per word, lane 0 = word bytes 0x00,0x10,0x20,0x30 in slots 0..3.
REQ-021 GEN=2, LANESNUMBER=2, outReady toggling 1,0,0,1 -> outputs frozen during 0 cycles; 16 beats total, no byte lost or duplicated.
REQ-022 LANESNUMBER=3, GEN=1 -> behaves as x1: 64 beats, outValid=0x0001.
REQ-023 Reset asserted at beat 5 of 16 -> next cycle all outputs 0, inReady=0; following cycle inReady=1, no residual beats.
REQ-024 With TX_STRIPE_IDLE_FILL_EN, x8 idle -> outValid=0x00FF, outData=0 until handshake; next beat is data.
